gdp_sum_engine: RTL

- Self-sequencing successor to the hand-driven sum-of-n general data path.
- Integrates the controller FSM and datapath in one block: start/busy/done handshake, parametrised operand and accumulator widths, programmable decrement step and overflow detection.
- Computes n + (n-step) + (n-2·step) + … over positive terms.
- Sits between a host or controller issuing jobs and any consumer of the result.

---
 rtl/gdp_sum_engine.sv | 122 ++++++++++++
 1 files changed

// File: rtl/gdp_sum_engine.sv
// gdp_sum_engine: self-sequencing sum-of-n engine.
// Computes n + (n-step) + (n-2*step) + ... over positive terms, with a
// start/busy/done handshake, a programmable decrement step (0 acts as 1)
// and a sticky overflow flag for the accumulator.
module gdp_sum_engine #(
  parameter int WIDTH     = 8,
  parameter int SUM_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     n_in,
  input  logic [WIDTH-1:0]     step_in,
  output logic                 busy,
  output logic                 done,
  output logic                 n_is_0,
  output logic [SUM_WIDTH-1:0] result,
  output logic                 overflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ADD,
    S_DEC,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     stp_q, stp_d;
  logic [SUM_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_acc_q, ovf_acc_d;
  logic [SUM_WIDTH-1:0] result_q, result_d;
  logic                 overflow_q, overflow_d;

  // Accumulate at SUM_WIDTH+1 bits so the top bit is the carry-out.
  logic [SUM_WIDTH:0] add_sum;
  assign add_sum = {1'b0, acc_q} + (SUM_WIDTH+1)'(cnt_q);

  // Next-state, datapath next values and state-decoded handshake outputs.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    stp_d      = stp_q;
    acc_d      = acc_q;
    ovf_acc_d  = ovf_acc_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    busy       = 1'b1;
    done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          cnt_d     = n_in;
          stp_d     = (step_in == '0) ? WIDTH'(1) : step_in;
          acc_d     = '0;
          ovf_acc_d = 1'b0;
          state_d   = S_CHECK;
        end
      end
      S_CHECK: begin
        if (cnt_q == '0) begin
          // Publish on the way into DONE so result/overflow are already
          // valid in the cycle that done is high.
          result_d   = acc_q;
          overflow_d = ovf_acc_q;
          state_d    = S_DONE;
        end else begin
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        acc_d     = add_sum[SUM_WIDTH-1:0];
        ovf_acc_d = ovf_acc_q | add_sum[SUM_WIDTH];
        state_d   = S_DEC;
      end
      S_DEC: begin
        // Saturate at zero so the counter never wraps below zero.
        cnt_d   = (cnt_q <= stp_q) ? '0 : cnt_q - stp_q;
        state_d = S_CHECK;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      stp_q      <= WIDTH'(1);
      acc_q      <= '0;
      ovf_acc_q  <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stp_q      <= stp_d;
      acc_q      <= acc_d;
      ovf_acc_q  <= ovf_acc_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  assign n_is_0   = (cnt_q == '0);
  assign result   = result_q;
  assign overflow = overflow_q;

endmodule
